hpdcache_repl_engine: RTL and testbench

//  Parametrised replacement engine for the HPDcache refill path. Generalises victim selection to

---
 rtl/hpdcache_pkg.sv | 37 +++
 rtl/hpdcache_repl_lfsr.sv | 29 ++
 rtl/hpdcache_repl_engine.sv | 192 +++++++++++++++++++
 tb/tb_hpdcache_repl_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared types and helpers for the HPDcache replacement engine.
package hpdcache_pkg;

    typedef enum logic [1:0] {
        REPL_RANDOM    = 2'd0,
        REPL_TREE_PLRU = 2'd1,
        REPL_BIT_PLRU  = 2'd2
    } hpdcache_repl_policy_e;

    // Priority one-hot encoder: keeps only the lowest set bit.
    function automatic logic [31:0] hpdcache_prio_1hot(input logic [31:0] x);
        return x & (~x + 32'd1);
    endfunction

    // Galois right-shift feedback masks giving maximal-length sequences.
    function automatic logic [31:0] hpdcache_lfsr_taps(input int unsigned w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/hpdcache_repl_lfsr.sv
// Galois LFSR with shift enable and a nonzero reset seed.
module hpdcache_repl_lfsr
    import hpdcache_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [31:0]      TAPS_ALL = hpdcache_lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= SEED;
        end else if (en_i) begin
            q <= (q >> 1) ^ (q[0] ? TAPS : '0);
        end
    end

    assign state_o = q;

endmodule

// File: rtl/hpdcache_repl_engine.sv
// Victim selection for the HPDcache refill path: lock mask, invalid-way
// preference, then random / tree-PLRU / bit-PLRU policy; result registered.
module hpdcache_repl_engine
    import hpdcache_pkg::*;
#(
    parameter int unsigned SETS   = 64,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned POLICY = 1,
    parameter int unsigned LFSR_W = 8,
    parameter int unsigned SET_W  = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             updt_i,
    input  logic [SET_W-1:0] updt_set_i,
    input  logic [WAYS-1:0]  updt_way_i,
    input  logic             repl_valid_i,
    output logic             repl_ready_o,
    input  logic [SET_W-1:0] repl_set_i,
    input  logic [WAYS-1:0]  repl_dir_valid_i,
    input  logic [WAYS-1:0]  repl_lock_i,
    input  logic             repl_updt_i,
    output logic             victim_valid_o,
    output logic [WAYS-1:0]  victim_way_o,
    output logic             victim_none_o
);

    localparam int unsigned IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam hpdcache_repl_policy_e POL = hpdcache_repl_policy_e'(POLICY[1:0]);

    function automatic logic [WAYS-1:0] lowest(input logic [WAYS-1:0] x);
        logic [31:0] t;
        t = hpdcache_prio_1hot(32'(x));
        return t[WAYS-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] oh2idx(input logic [WAYS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic            ready_q, valid_q, none_q;
    logic [WAYS-1:0] way_q;
    logic            accept, none, victim_touch;
    logic [WAYS-1:0] cand, free, policy_way, sel_way;

    assign accept       = repl_valid_i & ready_q;
    assign cand         = ~repl_lock_i;
    assign none         = ~|cand;
    assign free         = ~repl_dir_valid_i & cand;
    assign sel_way      = none ? '0 : (|free ? lowest(free) : policy_way);
    assign victim_touch = accept & repl_updt_i & ~none;

    generate
        if (WAYS == 1) begin : g_single
            assign policy_way = cand;
        end else if (POL == REPL_RANDOM) begin : g_rand
            logic [LFSR_W-1:0] lfsr;
            logic              lfsr_en;

            // Only requests that actually consult the policy advance the LFSR.
            assign lfsr_en = accept & ~none & ~|free;

            hpdcache_repl_lfsr #(.WIDTH(LFSR_W), .SEED(LFSR_W'(1))) u_lfsr (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .en_i    (lfsr_en),
                .state_o (lfsr)
            );

            always_comb begin
                int unsigned      start;
                logic             found;
                logic [IDX_W-1:0] j;
                start      = 32'(lfsr) % WAYS;
                found      = 1'b0;
                j          = '0;
                policy_way = '0;
                for (int unsigned i = 0; i < WAYS; i++) begin
                    j = IDX_W'((start + i) % WAYS);
                    if (!found && cand[j]) begin
                        policy_way[j] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        end else if (POL == REPL_TREE_PLRU) begin : g_tree
            localparam int unsigned TW = WAYS - 1;

            function automatic logic [IDX_W-1:0] tree_leaf(input logic [TW-1:0] t);
                int unsigned   node;
                logic [TW-1:0] sh;
                node = 0;
                for (int unsigned l = 0; l < IDX_W; l++) begin
                    sh   = t >> node;
                    node = 2 * node + 1 + 32'(sh[0]);
                end
                return IDX_W'(node - TW);
            endfunction

            // Each bit on the path is set to point away from the touched way.
            function automatic logic [TW-1:0] tree_touch(input logic [TW-1:0] t,
                                                         input logic [IDX_W-1:0] w);
                int unsigned      node;
                logic [TW-1:0]    r, bitsel;
                logic [IDX_W-1:0] ws;
                r    = t;
                node = 0;
                for (int unsigned l = 0; l < IDX_W; l++) begin
                    ws     = w >> (IDX_W - 1 - l);
                    bitsel = TW'(1) << node;
                    r      = ws[0] ? (r & ~bitsel) : (r | bitsel);
                    node   = 2 * node + 1 + 32'(ws[0]);
                end
                return r;
            endfunction

            logic [TW-1:0]   tree_q [SETS];
            logic [TW-1:0]   row_u, row_v;
            logic [WAYS-1:0] leaf_oh;

            assign leaf_oh    = WAYS'(1) << tree_leaf(tree_q[repl_set_i]);
            assign policy_way = |(leaf_oh & cand) ? leaf_oh : lowest(cand);
            assign row_u      = tree_touch(tree_q[updt_set_i], oh2idx(updt_way_i));
            assign row_v      = tree_touch((updt_i && updt_set_i == repl_set_i) ? row_u
                                                                                : tree_q[repl_set_i],
                                           oh2idx(sel_way));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
                end else begin
                    if (updt_i)       tree_q[updt_set_i] <= row_u;
                    if (victim_touch) tree_q[repl_set_i] <= row_v;
                end
            end
        end else begin : g_bit
            function automatic logic [WAYS-1:0] mru_touch(input logic [WAYS-1:0] r,
                                                          input logic [WAYS-1:0] oh);
                logic [WAYS-1:0] n;
                n = r | oh;
                if (&n) n = oh;
                return n;
            endfunction

            logic [WAYS-1:0] mru_q [SETS];
            logic [WAYS-1:0] not_mru, row_u, row_v;

            assign not_mru    = cand & ~mru_q[repl_set_i];
            assign policy_way = |not_mru ? lowest(not_mru) : lowest(cand);
            assign row_u      = mru_touch(mru_q[updt_set_i], updt_way_i);
            assign row_v      = mru_touch((updt_i && updt_set_i == repl_set_i) ? row_u
                                                                               : mru_q[repl_set_i],
                                          sel_way);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned s = 0; s < SETS; s++) mru_q[s] <= '0;
                end else begin
                    if (updt_i)       mru_q[updt_set_i] <= row_u;
                    if (victim_touch) mru_q[repl_set_i] <= row_v;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            none_q  <= 1'b0;
            way_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            valid_q <= accept;
            if (accept) begin
                none_q <= none;
                way_q  <= sel_way;
            end
        end
    end

    assign repl_ready_o   = ready_q;
    assign victim_valid_o = valid_q;
    assign victim_way_o   = way_q;
    assign victim_none_o  = none_q;

endmodule

// File: tb/tb_hpdcache_repl_engine.sv
// Directed bench: one engine instance per policy, shared stimulus.
module tb_hpdcache_repl_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       updt = 1'b0;
    logic [5:0] updt_set = '0;
    logic [3:0] updt_way = '0;
    logic       rvalid = 1'b0;
    logic [5:0] rset = '0;
    logic [3:0] rdir = '0;
    logic [3:0] rlock = '0;
    logic       rupdt = 1'b0;

    logic       ready_r, ready_t, ready_b;
    logic       vv_r, vv_t, vv_b;
    logic [3:0] vw_r, vw_t, vw_b;
    logic       vn_r, vn_t, vn_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpdcache_repl_engine #(.SETS(64), .WAYS(4), .POLICY(0), .LFSR_W(8)) u_rand (
        .clk_i(clk), .rst_i(rst), .updt_i(updt), .updt_set_i(updt_set), .updt_way_i(updt_way),
        .repl_valid_i(rvalid), .repl_ready_o(ready_r), .repl_set_i(rset),
        .repl_dir_valid_i(rdir), .repl_lock_i(rlock), .repl_updt_i(rupdt),
        .victim_valid_o(vv_r), .victim_way_o(vw_r), .victim_none_o(vn_r));

    hpdcache_repl_engine #(.SETS(64), .WAYS(4), .POLICY(1), .LFSR_W(8)) u_tree (
        .clk_i(clk), .rst_i(rst), .updt_i(updt), .updt_set_i(updt_set), .updt_way_i(updt_way),
        .repl_valid_i(rvalid), .repl_ready_o(ready_t), .repl_set_i(rset),
        .repl_dir_valid_i(rdir), .repl_lock_i(rlock), .repl_updt_i(rupdt),
        .victim_valid_o(vv_t), .victim_way_o(vw_t), .victim_none_o(vn_t));

    hpdcache_repl_engine #(.SETS(64), .WAYS(4), .POLICY(2), .LFSR_W(8)) u_bit (
        .clk_i(clk), .rst_i(rst), .updt_i(updt), .updt_set_i(updt_set), .updt_way_i(updt_way),
        .repl_valid_i(rvalid), .repl_ready_o(ready_b), .repl_set_i(rset),
        .repl_dir_valid_i(rdir), .repl_lock_i(rlock), .repl_updt_i(rupdt),
        .victim_valid_o(vv_b), .victim_way_o(vw_b), .victim_none_o(vn_b));

    always @(posedge clk) begin
        if (!rst && updt) assert ($onehot(updt_way)) else $error("illegal updt_way %b", updt_way);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [5:0] set, input logic [3:0] dir, input logic [3:0] lock,
                       input logic upd);
        rvalid = 1'b1; rset = set; rdir = dir; rlock = lock; rupdt = upd;
        @(posedge clk); #1;
        rvalid = 1'b0; rupdt = 1'b0;
    endtask

    task automatic touch(input logic [5:0] set, input logic [3:0] way);
        updt = 1'b1; updt_set = set; updt_way = way;
        @(posedge clk); #1;
        updt = 1'b0;
    endtask

    int cnt[4];
    int bad;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_t, 0);
        chk("rst_valid", vv_t, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", ready_t, 1);
        chk("valid_idle", vv_t, 0);
        chk("way_idle", vw_t, 4'b0000);
        chk("none_idle", vn_t, 0);

        // invalid-way preference, one-cycle result pulse
        req(6'd3, 4'b0000, 4'b0000, 1'b0);
        chk("free_valid", vv_t, 1);
        chk("free_way_tree", vw_t, 4'b0001);
        chk("free_way_bit", vw_b, 4'b0001);
        chk("free_way_rand", vw_r, 4'b0001);
        chk("free_none", vn_t, 0);
        @(posedge clk); #1;
        chk("valid_pulse", vv_t, 0);

        // bit-PLRU saturation in set 5
        touch(6'd5, 4'b0001);
        touch(6'd5, 4'b0010);
        touch(6'd5, 4'b0100);
        req(6'd5, 4'b1111, 4'b0000, 1'b0);
        chk("bit_3touch", vw_b, 4'b1000);
        chk("tree_3touch", vw_t, 4'b0001);
        touch(6'd5, 4'b1000);
        req(6'd5, 4'b1111, 4'b0000, 1'b0);
        chk("bit_wrap", vw_b, 4'b0001);
        chk("tree_4touch", vw_t, 4'b0001);

        // tree-PLRU path walk and locked leaf in set 0
        touch(6'd0, 4'b0001);
        req(6'd0, 4'b1111, 4'b0000, 1'b0);
        chk("tree_touch0", vw_t, 4'b0100);
        chk("bit_touch0", vw_b, 4'b0010);
        req(6'd0, 4'b1111, 4'b0100, 1'b0);
        chk("tree_leaf_locked", vw_t, 4'b0001);
        chk("bit_lock", vw_b, 4'b0010);

        // all ways locked: no victim and no state change even with repl_updt
        req(6'd0, 4'b1111, 4'b1111, 1'b1);
        chk("none_valid", vv_t, 1);
        chk("none_tree", vn_t, 1);
        chk("none_way_tree", vw_t, 4'b0000);
        chk("none_bit", vn_b, 1);
        chk("none_rand", vn_r, 1);
        chk("none_way_rand", vw_r, 4'b0000);
        req(6'd0, 4'b1111, 4'b0000, 1'b0);
        chk("none_kept_tree", vw_t, 4'b0100);
        chk("none_kept_bit", vw_b, 4'b0010);

        // free way among unlocked ways
        req(6'd1, 4'b1011, 4'b0000, 1'b0);
        chk("free_mid_tree", vw_t, 4'b0100);
        chk("free_mid_rand", vw_r, 4'b0100);
        req(6'd1, 4'b0000, 4'b0011, 1'b0);
        chk("free_locked_bit", vw_b, 4'b0100);

        // same-set touch and victim touch in one cycle
        updt = 1'b1; updt_set = 6'd2; updt_way = 4'b0010;
        req(6'd2, 4'b1111, 4'b0000, 1'b1);
        updt = 1'b0;
        chk("same_old_tree", vw_t, 4'b0001);
        chk("same_old_bit", vw_b, 4'b0001);
        req(6'd2, 4'b1111, 4'b0000, 1'b0);
        chk("same_after_bit", vw_b, 4'b0100);
        chk("same_after_tree", vw_t, 4'b0100);

        // different sets in one cycle
        updt = 1'b1; updt_set = 6'd6; updt_way = 4'b0001;
        req(6'd7, 4'b1111, 4'b0000, 1'b1);
        updt = 1'b0;
        chk("diff_tree", vw_t, 4'b0001);
        req(6'd6, 4'b1111, 4'b0000, 1'b0);
        chk("diff6_tree", vw_t, 4'b0100);
        chk("diff6_bit", vw_b, 4'b0010);
        req(6'd7, 4'b1111, 4'b0000, 1'b0);
        chk("diff7_tree", vw_t, 4'b0100);
        chk("diff7_bit", vw_b, 4'b0010);

        // random policy honours locks
        for (int i = 0; i < 8; i++) begin
            req(6'd1, 4'b1111, 4'b0010, 1'b0);
            chk("rand_lock_hit", vw_r & 4'b0010, 4'b0000);
            chk("rand_lock_1hot", $countones(vw_r), 1);
        end

        // random distribution over a full LFSR period
        bad = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 256; i++) begin
            req(6'd1, 4'b1111, 4'b0000, 1'b0);
            case (vw_r)
                4'b0001: cnt[0]++;
                4'b0010: cnt[1]++;
                4'b0100: cnt[2]++;
                4'b1000: cnt[3]++;
                default: bad++;
            endcase
        end
        chk("rand_bad", bad, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rand_cnt%0d", i), (cnt[i] >= 32), 1);

        // reset while a result is pending
        rvalid = 1'b1; rset = 6'd0; rdir = 4'b1111; rlock = 4'b0000;
        @(posedge clk); #1;
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", vv_t, 0);
        chk("midrst_ready", ready_t, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_valid", vv_t, 0);
        chk("postrst_ready", ready_t, 1);
        req(6'd0, 4'b1111, 4'b0000, 1'b0);
        chk("postrst_tree", vw_t, 4'b0001);
        chk("postrst_bit", vw_b, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
